divisor_parametrico: RTL and testbench

Sequential, parametrised integer divider for the ALU: restoring division producing one quotient bit per clock. It adds operand width configurability, a run-time signed/unsigned mode, a start/done handshake, and divide-by-zero and overflow flags. It sits beside the other ALU arithmetic units and is driven by the ALU control logic, which issues `start` and waits for `done`.

---
 rtl/divisor_parametrico.sv | 172 +++++++++++++++++
 tb/tb_divisor_parametrico.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_parametrico.sv
// Sequential restoring divider, one quotient bit per clock, with signed/unsigned mode,
// start/done handshake and divide-by-zero / signed-overflow flags.
module divisor_parametrico #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Cociente,
    output logic [WIDTH-1:0] Residuo,
    output logic             busy,
    output logic             done,
    output logic             div_cero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] coc_q, coc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_cero_q, div_cero_d;
    logic             overflow_q, overflow_d;

    logic             a_neg, b_neg, ge;
    logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;
    logic [WIDTH:0]   partial;

    assign Cociente = coc_q;
    assign Residuo  = res_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_cero = div_cero_q;
    assign overflow = overflow_q;

    // Next-state, datapath and output logic
    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        coc_d      = coc_q;
        res_d      = res_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_cero_d = div_cero_q;
        overflow_d = overflow_q;

        a_neg   = signed_mode & A[WIDTH-1];
        b_neg   = signed_mode & B[WIDTH-1];
        a_mag   = a_neg ? -A : A;
        b_mag   = b_neg ? -B : B;
        partial = {rem_q, dvd_q[WIDTH-1]};
        ge      = (partial >= {1'b0, dvs_q});
        q_fin   = qneg_q ? -dvd_q : dvd_q;
        r_fin   = rneg_q ? -rem_q : rem_q;

        case (state_q)
            IDLE: begin
                busy_d = start;
                if (start) begin
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    dvs_d  = b_mag;
                    ovf_d  = signed_mode && (A == MOST_NEG) && (B == '1);
                    rem_d  = '0;
                    if (B == '0) begin
                        // Raw dividend kept for the remainder output
                        dvd_d   = A;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = FIN;
                    end else begin
                        dvd_d   = a_mag;
                        dz_d    = 1'b0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], ge};
                rem_d = ge ? WIDTH'(partial - {1'b0, dvs_q}) : partial[WIDTH-1:0];
                if (cnt_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIN: begin
                done_d     = 1'b1;
                div_cero_d = dz_q;
                overflow_d = ovf_q;
                if (dz_q) begin
                    coc_d = '1;
                    res_d = dvd_q;
                end else if (ovf_q) begin
                    coc_d = MOST_NEG;
                    res_d = '0;
                end else begin
                    coc_d = q_fin;
                    res_d = r_fin;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            coc_q      <= '0;
            res_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_cero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            coc_q      <= coc_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_cero_q <= div_cero_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_divisor_parametrico.sv
// Bench for divisor_parametrico: 8-bit and 16-bit instances checked every cycle against an
// arithmetic reference model, plus literal expectations for the directed vectors.
module tb_divisor_parametrico;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start;
    logic [1:0]  sm;
    logic [31:0] a [2];
    logic [31:0] b [2];

    logic [7:0]  q8, r8;
    logic [15:0] q16, r16;
    logic        busy8, done8, dz8, ov8;
    logic        busy16, done16, dz16, ov16;

    int tests = 0;
    int fails = 0;
    int unsigned wid [2] = '{8, 16};

    always #5 clk = ~clk;

    divisor_parametrico #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst_n), .start(start[0]), .signed_mode(sm[0]),
        .A(a[0][7:0]), .B(b[0][7:0]), .Cociente(q8), .Residuo(r8),
        .busy(busy8), .done(done8), .div_cero(dz8), .overflow(ov8)
    );

    divisor_parametrico #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst_n), .start(start[1]), .signed_mode(sm[1]),
        .A(a[1][15:0]), .B(b[1][15:0]), .Cociente(q16), .Residuo(r16),
        .busy(busy16), .done(done16), .div_cero(dz16), .overflow(ov16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask_of(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    // Truncating division on plain integers, with the divide-by-zero and overflow rules
    function automatic void ref_div(input int unsigned w, input bit s, input logic [31:0] av,
                                    input logic [31:0] bv, output bit [31:0] q,
                                    output bit [31:0] r, output bit dz, output bit ov);
        longint sa, sb, msk;
        msk = (longint'(1) << w) - 1;
        dz  = 1'b0;
        ov  = 1'b0;
        if (bv == 32'd0) begin
            dz = 1'b1;
            q  = mask_of(w);
            r  = av;
        end else if (s) begin
            sa = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
            sb = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
            if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                ov = 1'b1;
                q  = av;
                r  = 32'd0;
            end else begin
                q = 32'((sa / sb) & msk);
                r = 32'((sa % sb) & msk);
            end
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endfunction

    bit          m_busy [2], m_done [2], m_dz [2], m_ov [2], p_dz [2], p_ov [2];
    bit   [31:0] m_q [2], m_r [2], p_q [2], p_r [2];
    int          m_left [2];

    // Transaction-level expectation: result appears a fixed number of edges after acceptance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 0; m_done[d] = 0; m_left[d] = 0;
                m_q[d] = 0; m_r[d] = 0; m_dz[d] = 0; m_ov[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d] || m_done[d]) begin
                    m_done[d] = 0;
                    if (start[d]) begin
                        ref_div(wid[d], sm[d], a[d] & mask_of(wid[d]), b[d] & mask_of(wid[d]),
                                p_q[d], p_r[d], p_dz[d], p_ov[d]);
                        m_busy[d] = 1;
                        m_left[d] = p_dz[d] ? 1 : int'(wid[d]) + 1;
                    end else begin
                        m_busy[d] = 0;
                    end
                end else begin
                    m_left[d]--;
                    if (m_left[d] == 0) begin
                        m_done[d] = 1;
                        m_q[d] = p_q[d]; m_r[d] = p_r[d];
                        m_dz[d] = p_dz[d]; m_ov[d] = p_ov[d];
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("busy8", 32'(busy8), 32'(m_busy[0]));
        chk("done8", 32'(done8), 32'(m_done[0]));
        chk("coc8", 32'(q8), m_q[0]);
        chk("res8", 32'(r8), m_r[0]);
        chk("dz8", 32'(dz8), 32'(m_dz[0]));
        chk("ov8", 32'(ov8), 32'(m_ov[0]));
        chk("busy16", 32'(busy16), 32'(m_busy[1]));
        chk("done16", 32'(done16), 32'(m_done[1]));
        chk("coc16", 32'(q16), m_q[1]);
        chk("res16", 32'(r16), m_r[1]);
        chk("dz16", 32'(dz16), 32'(m_dz[1]));
        chk("ov16", 32'(ov16), 32'(m_ov[1]));
    end

    task automatic wait_done(input int d, output int n);
        n = 0;
        while (!(d == 1 ? done16 : done8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 32'(n), 32'd0);
    endtask

    // Called at a negedge; start is sampled on the next rising edge
    task automatic do_op(input int d, input bit s, input logic [31:0] av, input logic [31:0] bv,
                         input int lat, input bit lit, input logic [31:0] eq,
                         input logic [31:0] er, input bit edz, input bit eov);
        int n;
        start[d] = 1'b1; sm[d] = s; a[d] = av; b[d] = bv;
        @(negedge clk);
        start[d] = 1'b0; sm[d] = ~s; a[d] = $urandom; b[d] = $urandom;
        wait_done(d, n);
        chk("latency", 32'(n), 32'(lat));
        if (lit) begin
            chk("lit_coc", 32'(q8), eq);
            chk("lit_res", 32'(r8), er);
            chk("lit_dz", 32'(dz8), 32'(edz));
            chk("lit_ov", 32'(ov8), 32'(eov));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit [31:0] tq, tr;
        bit tdz, tov;
        logic [31:0] av, bv;
        bit s;

        rst_n = 1'b0; start = '0; sm = '0;
        a[0] = 0; b[0] = 0; a[1] = 0; b[1] = 0;

        ref_div(8, 1'b1, 32'hE2, 32'h04, tq, tr, tdz, tov);
        chk("model_q", tq, 32'hF9);
        chk("model_r", tr, 32'hFE);
        ref_div(8, 1'b1, 32'h80, 32'hFF, tq, tr, tdz, tov);
        chk("model_ov", 32'(tov), 32'd1);

        repeat (3) @(negedge clk);
        chk("rst_coc", 32'(q8), 32'd0);
        chk("rst_res", 32'(r8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 1, 32'hE2, 32'h04, 9, 1, 32'hF9, 32'hFE, 0, 0);
        do_op(0, 1, 32'hC8, 32'hE9, 9, 1, 32'h02, 32'hF6, 0, 0);
        do_op(0, 1, 32'd56, 32'd3, 9, 1, 32'd18, 32'd2, 0, 0);
        do_op(0, 0, 32'd200, 32'd7, 9, 1, 32'd28, 32'd4, 0, 0);
        do_op(0, 1, 32'h80, 32'hFF, 9, 1, 32'h80, 32'h00, 0, 1);
        do_op(0, 0, 32'h4C, 32'h00, 1, 1, 32'hFF, 32'h4C, 1, 0);
        do_op(0, 1, 32'h4C, 32'h00, 1, 1, 32'hFF, 32'h4C, 1, 0);
        do_op(0, 1, 32'd56, 32'd3, 9, 1, 32'd18, 32'd2, 0, 0);
        do_op(0, 0, 32'hFF, 32'h01, 9, 1, 32'hFF, 32'h00, 0, 0);
        do_op(0, 0, 32'h80, 32'hFF, 9, 1, 32'h00, 32'h80, 0, 0);
        do_op(0, 1, 32'h7F, 32'h80, 9, 1, 32'h00, 32'h7F, 0, 0);

        // start pulsed while busy is ignored
        start[0] = 1; sm[0] = 0; a[0] = 100; b[0] = 9;
        @(negedge clk); start[0] = 0;
        @(negedge clk); @(negedge clk);
        start[0] = 1; a[0] = 1; b[0] = 1;
        @(negedge clk); start[0] = 0;
        wait_done(0, n);
        chk("ign_lat", 32'(n), 32'd6);
        chk("ign_coc", 32'(q8), 32'd11);
        chk("ign_res", 32'(r8), 32'd1);

        // start held high: next operation accepted on the edge after done
        start[0] = 1; sm[0] = 0; a[0] = 200; b[0] = 7;
        @(negedge clk);
        wait_done(0, n);
        chk("hold_lat1", 32'(n), 32'd9);
        chk("hold_coc1", 32'(q8), 32'd28);
        a[0] = 100; b[0] = 9;
        @(negedge clk); start[0] = 0;
        chk("hold_busy", 32'(busy8), 32'd1);
        wait_done(0, n);
        chk("hold_lat2", 32'(n), 32'd9);
        chk("hold_coc2", 32'(q8), 32'd11);
        chk("hold_res2", 32'(r8), 32'd1);

        // reset mid-operation
        @(negedge clk);
        start[0] = 1; sm[0] = 0; a[0] = 77; b[0] = 5;
        @(negedge clk); start[0] = 0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_coc", 32'(q8), 32'd0);
        chk("arst_res", 32'(r8), 32'd0);
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_dz", 32'(dz8), 32'd0);
        chk("arst_ov", 32'(ov8), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done8), 32'd0);
            chk("post_rst_busy", 32'(busy8), 32'd0);
        end

        // 16-bit back-to-back mixed-mode operations
        for (int i = 0; i < 1000; i++) begin
            av = $urandom & 32'hFFFF;
            bv = $urandom & 32'hFFFF;
            s  = 1'($urandom);
            if (bv == 0) bv = 1;
            if (i == 0) begin av = 32'h8000; bv = 32'hFFFF; s = 1; end
            if (i == 1) begin av = 32'h8000; bv = 32'h0001; s = 1; end
            if (i == 2) begin av = 32'hFFFF; bv = 32'hFFFF; s = 0; end
            do_op(1, s, av, bv, 17, 0, 0, 0, 0, 0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
